// File: rtl/dac_sample_fifo.sv
// -----------------------------------------------------------------------------
// dac_sample_fifo
//
// Purpose:
//    Decouples the sample-producing core from a parallel DAC. Samples are
//    written into a small circular buffer at core rate and drained one per
//    DAC update tick. Ticks come from a clk divider (one tick every DIV
//    cycles while enabled). Each pop loads the DAC code register and raises
//    a one-cycle strobe after it. An empty buffer at tick time is recorded
//    as an underflow, and the DAC code is held.
//
// Parameters:
//    WIDTH  sample width in bits
//    DEPTH  number of buffer entries (power of two, >= 2)
//    DIV    clk cycles per DAC update tick (>= 1)
//
// Ports:
//    clk           single clock shared with the core
//    reset         asynchronous active-high reset
//    enable        high = tick generation and draining active
//    in_data       sample from the core
//    in_valid      in_data is valid this cycle
//    in_ready      buffer can accept a sample this cycle
//    dac_d         registered code driven to the DAC D input
//    dac_strobe    one-cycle pulse in the cycle after dac_d was loaded
//    level         current buffer occupancy (0..DEPTH)
//    underflow     sticky flag: a tick found the buffer empty
//    underrun_cnt  saturating count of empty ticks
//    clear_err     synchronous clear of underflow and underrun_cnt
// -----------------------------------------------------------------------------
module dac_sample_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int DIV   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         dac_d,
   output logic                     dac_strobe,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     underflow,
   output logic [7:0]               underrun_cnt,
   input  logic                     clear_err
);

   // ------------------------------------------------------------------
   // Derived widths and constants
   // ------------------------------------------------------------------
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [TW-1:0] TCNT_LAST = TW'(DIV - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
   logic [LW-1:0]    level_q,     level_d;
   logic [TW-1:0]    tcnt_q,      tcnt_d;
   logic [WIDTH-1:0] dac_d_q;
   logic             strobe_q,    strobe_d;
   logic             underflow_q, underflow_d;
   logic [7:0]       urun_cnt_q,  urun_cnt_d;

   // ------------------------------------------------------------------
   // Handshake and event decode
   // ------------------------------------------------------------------
   logic full;
   logic empty;
   logic tick;
   logic push;
   logic pop;
   logic empty_tick;

   // Full/empty are taken from the registered level only: a pop in the
   // same cycle does not open a slot for a push (no bypass), and a push in
   // the same cycle does not rescue an empty tick.
   assign full       = (level_q == LVL_FULL);
   assign empty      = (level_q == '0);
   assign tick       = enable && (tcnt_q == TCNT_LAST);
   assign push       = in_valid && !full;
   assign pop        = tick && !empty;
   assign empty_tick = tick && empty;

   assign in_ready   = !full;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      tcnt_d      = tcnt_q;
      strobe_d    = pop;
      underflow_d = underflow_q;
      urun_cnt_d  = urun_cnt_q;

      // Explicit wrap keeps the pointer arithmetic obvious even though the
      // power-of-two depth would wrap naturally.
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // Divider parks at 0 while disabled so the first tick after enable
      // (or after reset) lands exactly DIV cycles later.
      if (!enable) begin
         tcnt_d = '0;
      end else if (tcnt_q == TCNT_LAST) begin
         tcnt_d = '0;
      end else begin
         tcnt_d = tcnt_q + TW'(1);
      end

      // A new empty tick wins over clear_err: the clear wipes the old
      // history and this tick becomes the first recorded underrun.
      if (empty_tick) begin
         underflow_d = 1'b1;
         if (clear_err) begin
            urun_cnt_d = 8'd1;
         end else if (urun_cnt_q != 8'hFF) begin
            urun_cnt_d = urun_cnt_q + 8'd1;
         end
      end else if (clear_err) begin
         underflow_d = 1'b0;
         urun_cnt_d  = 8'd0;
      end
   end

   // ------------------------------------------------------------------
   // Sample storage: no reset, so it maps onto block/distributed RAM.
   // Contents are made irrelevant on reset by clearing the pointers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // ------------------------------------------------------------------
   // DAC code register: the registered RAM read port. It only changes on
   // a pop, so the DAC sees a stable code between updates.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dac_d_q <= '0;
      end else if (pop) begin
         dac_d_q <= mem_q[rd_ptr_q];
      end
   end

   // ------------------------------------------------------------------
   // Control state registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         tcnt_q      <= '0;
         strobe_q    <= 1'b0;
         underflow_q <= 1'b0;
         urun_cnt_q  <= 8'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         tcnt_q      <= tcnt_d;
         strobe_q    <= strobe_d;
         underflow_q <= underflow_d;
         urun_cnt_q  <= urun_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign dac_d        = dac_d_q;
   assign dac_strobe   = strobe_q;
   assign level        = level_q;
   assign underflow    = underflow_q;
   assign underrun_cnt = urun_cnt_q;

endmodule

// File: tb/tb_dac_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_dac_sample_fifo
//
// Self-checking bench for dac_sample_fifo (WIDTH=10, DEPTH=8, DIV=4).
// A cycle model predicts level, in_ready, strobe, flags and the held DAC
// code. Accepted samples are pushed to a scoreboard queue and popped and
// compared whenever the DUT raises dac_strobe.
// -----------------------------------------------------------------------------
module tb_dac_sample_fifo;

   localparam int WIDTH = 10;
   localparam int DEPTH = 8;
   localparam int DIV   = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             enable = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             clear_err = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] dac_d;
   logic             dac_strobe;
   logic [3:0]       level;
   logic             underflow;
   logic [7:0]       underrun_cnt;

   int total = 0;
   int bad = 0;
   int strobes = 0;

   // model state
   logic [WIDTH-1:0] m_fifo [$];
   logic [WIDTH-1:0] sb [$];
   int               m_level = 0;
   int               m_tcnt = 0;
   int               m_cnt = 0;
   logic             m_uf = 1'b0;
   logic             m_strobe = 1'b0;
   logic [WIDTH-1:0] m_dac = '0;

   dac_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .dac_d        (dac_d),
      .dac_strobe   (dac_strobe),
      .level        (level),
      .underflow    (underflow),
      .underrun_cnt (underrun_cnt),
      .clear_err    (clear_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic check_outputs();
      logic [WIDTH-1:0] e;
      chk("level",     32'(level),        32'(m_level));
      chk("in_ready",  32'(in_ready),     32'(m_level != DEPTH));
      chk("strobe",    32'(dac_strobe),   32'(m_strobe));
      chk("underflow", 32'(underflow),    32'(m_uf));
      chk("urun_cnt",  32'(underrun_cnt), 32'(m_cnt));
      chk("dac_hold",  32'(dac_d),        32'(m_dac));
      if (dac_strobe === 1'b1) begin
         strobes++;
         chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("dac_vs_sb", 32'(dac_d), 32'(e));
            $display("strobe: dac_d=0x%03h expected=0x%03h level=%0d", dac_d, e, level);
         end
      end
   endtask

   // Advance one clock: predict the effect of the coming edge, then check
   // the DUT on the following falling edge.
   task automatic cycle();
      logic tick, push, pop;
      tick = enable && (m_tcnt == DIV - 1);
      push = in_valid && (m_level != DEPTH);
      pop  = tick && (m_level != 0);
      if (pop) m_dac = m_fifo.pop_front();
      m_strobe = pop;
      if (push) begin
         m_fifo.push_back(in_data);
         sb.push_back(in_data);
      end
      m_level = m_fifo.size();
      if (!enable || tick) m_tcnt = 0;
      else m_tcnt++;
      if (tick && !pop) begin
         m_uf  = 1'b1;
         m_cnt = clear_err ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (clear_err) begin
         m_uf  = 1'b0;
         m_cnt = 0;
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      m_fifo.delete();
      sb.delete();
      m_level = 0; m_tcnt = 0; m_cnt = 0;
      m_uf = 1'b0; m_strobe = 1'b0; m_dac = '0;
      #1;
      check_outputs();
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic write(input logic [WIDTH-1:0] v);
      in_valid = 1'b1;
      in_data  = v;
      cycle();
      in_valid = 1'b0;
   endtask

   initial begin
      int first;
      #2;
      do_reset(2);

      // back-to-back writes drained on ticks 4 cycles apart
      enable = 1'b1;
      strobes = 0;
      write(10'h001);
      write(10'h3FF);
      write(10'h155);
      run(20);
      chk("t1_strobes", 32'(strobes), 32'd3);
      chk("t1_last_dac", 32'(dac_d), 32'h155);
      enable = 1'b0;
      cycle();

      // fill while disabled, 9th write dropped, then drain in order
      for (int i = 0; i < 9; i++) write(WIDTH'($urandom_range(0, 1023)));
      chk("t2_level", 32'(level), 32'd8);
      chk("t2_ready", 32'(in_ready), 32'd0);
      strobes = 0;
      enable = 1'b1;
      run(8 * DIV + 4);
      chk("t2_strobes", 32'(strobes), 32'd8);
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);
      enable = 1'b0;
      cycle();

      // full FIFO, tick coincides with a refused write
      for (int i = 0; i < 8; i++) write(WIDTH'(10'h200 + i));
      enable = 1'b1;
      in_valid = 1'b1;
      in_data = 10'h0AA;
      run(DIV);
      in_valid = 1'b0;
      chk("t3_level", 32'(level), 32'd7);
      run(8 * DIV);
      enable = 1'b0;
      cycle();

      // empty ticks and clear_err
      do_reset(1);
      enable = 1'b1;
      run(3 * DIV);
      chk("t4_dac", 32'(dac_d), 32'd0);
      chk("t4_uf", 32'(underflow), 32'd1);
      chk("t4_cnt", 32'(underrun_cnt), 32'd3);
      clear_err = 1'b1;
      cycle();
      clear_err = 1'b0;
      chk("t4_uf_clr", 32'(underflow), 32'd0);
      chk("t4_cnt_clr", 32'(underrun_cnt), 32'd0);
      enable = 1'b0;
      cycle();

      // reset mid tick period with level 5
      for (int i = 0; i < 5; i++) write(WIDTH'(10'h300 + i));
      enable = 1'b1;
      run(2);
      chk("t5_level_pre", 32'(level), 32'd5);
      do_reset(1);
      chk("t5_level_post", 32'(level), 32'd0);
      chk("t5_dac_post", 32'(dac_d), 32'd0);
      first = -1;
      in_valid = 1'b1;
      in_data = 10'h2C3;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         in_valid = 1'b0;
         if (dac_strobe === 1'b1 && first < 0) first = i;
      end
      chk("t5_first_tick", 32'(first), 32'(DIV));

      // push on an empty tick, then sustained push/pop streaming
      do_reset(1);
      enable = 1'b1;
      run(DIV - 1);
      write(10'h111);
      chk("t6_uf", 32'(underflow), 32'd1);
      chk("t6_level", 32'(level), 32'd1);
      for (int i = 0; i < 24; i++) write(WIDTH'(10'h040 + i));
      run(12 * DIV);

      // saturation and clear coinciding with an empty tick
      do_reset(1);
      enable = 1'b1;
      run(300 * DIV);
      chk("t7_sat", 32'(underrun_cnt), 32'd255);
      run(DIV - 1);
      clear_err = 1'b1;
      cycle();
      clear_err = 1'b0;
      chk("t7_clr_cnt", 32'(underrun_cnt), 32'd1);
      chk("t7_clr_uf", 32'(underflow), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
